// File: rtl/icache_axi_rd_bridge.sv
// Icache refill / uncached-fetch responder: splits one word-granular read request
// into AXI INCR bursts of at most MAX_BURST beats and streams the words back in order.
module icache_axi_rd_bridge #(
    parameter logic [3:0]  AXI_ID    = 4'd0,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [7:0]        req_len_i,
    output logic              req_ready_o,
    output logic              rdata_valid_o,
    output logic [31:0]       rdata_o,
    output logic              rerr_o,
    output logic              busy_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic [3:0]        arid_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [31:0]       rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic [3:0]        rid_i
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_rem;
    logic [7:0]        r_beats;
    logic [7:0]        r_cnt;
    logic              r_first;
    logic              r_abort;
    logic              r_len0_ack;
    logic              r_rdata_valid;
    logic [31:0]       r_rdata;
    logic              r_rerr;

    logic              w_ar_hs;
    logic              w_beat;
    logic              w_counted;
    logic              w_abort;
    logic [7:0]        w_burst;
    logic [7:0]        w_rem_nxt;

    assign w_ar_hs   = (r_state == S_AR) && arready_i;
    assign w_beat    = rvalid_i && (rid_i == AXI_ID);
    // Beats past the expected count (late rlast) are consumed but neither counted nor forwarded.
    assign w_counted = w_beat && (r_cnt < r_beats);
    assign w_abort   = flush_i || r_abort;
    assign w_burst   = (r_rem > 8'(MAX_BURST)) ? 8'(MAX_BURST) : r_rem;
    assign w_rem_nxt = w_counted ? r_rem - 8'd1 : r_rem;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i && !flush_i && (req_len_i != 8'd0))
                    w_next = S_AR;
            end
            S_AR: begin
                if (arready_i)
                    w_next = w_abort ? S_DRAIN : S_R;
            end
            S_R: begin
                if (w_beat && rlast_i)
                    w_next = (flush_i || (w_rem_nxt == 8'd0)) ? S_IDLE : S_AR;
                else if (flush_i)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_beat && rlast_i)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_rem         <= '0;
            r_beats       <= '0;
            r_cnt         <= '0;
            r_first       <= 1'b0;
            r_abort       <= 1'b0;
            r_len0_ack    <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_rerr        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_len0_ack    <= 1'b0;
            r_rdata_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        r_addr     <= req_addr_i;
                        r_rem      <= req_len_i;
                        r_rerr     <= 1'b0;
                        r_first    <= 1'b1;
                        r_abort    <= 1'b0;
                        r_len0_ack <= (req_len_i == 8'd0);
                    end
                end
                S_AR: begin
                    // arvalid is already up in AR, so a flush must wait for the handshake.
                    if (flush_i)
                        r_abort <= 1'b1;
                    if (arready_i) begin
                        r_beats <= w_burst;
                        r_cnt   <= '0;
                        r_first <= 1'b0;
                    end
                end
                S_R: begin
                    if (w_counted) begin
                        r_rem  <= r_rem - 8'd1;
                        r_addr <= r_addr + ADDR_W'(4);
                        r_cnt  <= r_cnt + 8'd1;
                        r_rerr <= r_rerr | (rresp_i != 2'b00);
                        if (!flush_i) begin
                            r_rdata_valid <= 1'b1;
                            r_rdata       <= rdata_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o   = r_len0_ack || (w_ar_hs && r_first && !w_abort);
    assign rdata_valid_o = r_rdata_valid;
    assign rdata_o       = r_rdata;
    assign rerr_o        = r_rerr;
    assign busy_o        = (r_state != S_IDLE);
    assign arvalid_o     = (r_state == S_AR);
    assign araddr_o      = (r_state == S_AR) ? r_addr : '0;
    assign arlen_o       = (r_state == S_AR) ? (w_burst - 8'd1) : '0;
    assign arsize_o      = 3'b010;
    assign arburst_o     = 2'b01;
    assign arid_o        = AXI_ID;
    assign rready_o      = (r_state == S_R) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: table of request scenarios with a bench-side
// AXI read slave, plus hand sequences for flush-in-AR and reset mid-burst.
module tb_icache_axi_rd_bridge;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        req_valid_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_len_i;
    logic        req_ready_o;
    logic        rdata_valid_o;
    logic [31:0] rdata_o;
    logic        rerr_o;
    logic        busy_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic [3:0]  arid_o;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rlast_i;
    logic [3:0]  rid_i;

    icache_axi_rd_bridge #(.AXI_ID(4'd0), .MAX_BURST(16), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .req_ready_o(req_ready_o), .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
        .rerr_o(rerr_o), .busy_o(busy_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arid_o(arid_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i), .rid_i(rid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          ardly;
        int          err_beat;
        bit          foreign;
        int          flush_after;
        logic [31:0] dbase;
        int          exp_nar;
        logic [7:0]  exp_arlen0;
        logic [7:0]  exp_arlen_last;
        int          exp_words;
        logic        exp_rerr;
        int          exp_rr;
        int          exp_rr_off;
        int          exp_stall;
        int          exp_span;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, sampled on the falling edge
    logic [31:0] q_data[$];
    logic [31:0] q_araddr[$];
    logic [7:0]  q_arlen[$];
    int n_rr, n_rr_off, n_stall, n_unstable, n_overlap;
    int cyc, first_cyc, last_cyc;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;

    initial begin
        cyc = 0; prev_stall = 1'b0; prev_addr = '0; prev_len = '0;
    end

    task automatic clear_mon;
        q_data.delete(); q_araddr.delete(); q_arlen.delete();
        n_rr = 0; n_rr_off = 0; n_stall = 0; n_unstable = 0; n_overlap = 0;
        first_cyc = -1; last_cyc = -1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (req_ready_o) begin
            n_rr++;
            if (!(arvalid_o && arready_i)) n_rr_off++;
        end
        if (rdata_valid_o) begin
            q_data.push_back(rdata_o);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (req_ready_o) n_overlap++;
        end
        if (arvalid_o) begin
            if (prev_stall && (araddr_o != prev_addr || arlen_o != prev_len)) n_unstable++;
            if (arready_i) begin
                q_araddr.push_back(araddr_o);
                q_arlen.push_back(arlen_o);
            end else begin
                n_stall++;
            end
            prev_stall = !arready_i;
            prev_addr  = araddr_o;
            prev_len   = arlen_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_len_i = '0;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
        rlast_i = 1'b0; rid_i = 4'd0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && busy_o; i++) tick;
        chk({name, "_idle"}, 32'(busy_o), 32'd0);
        repeat (2) tick;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int  rem, k, b;
        bit  flushed, fdone;
        clear_mon();
        flushed = 1'b0; fdone = 1'b0;
        req_valid_i = 1'b1; req_addr_i = v.addr; req_len_i = 8'(v.len);
        tick;
        req_valid_i = 1'b0;
        if (v.len == 0) begin
            repeat (3) tick;
        end else begin
            rem = v.len; k = 0;
            while (rem > 0 && !flushed) begin
                b = (rem > 16) ? 16 : rem;
                repeat (v.ardly) tick;
                arready_i = 1'b1;
                tick;
                arready_i = 1'b0;
                for (int j = 0; j < b; j++) begin
                    if (v.foreign && k == 2 && !fdone) begin
                        rvalid_i = 1'b1; rid_i = 4'd5; rdata_i = 32'hDEAD_BEEF;
                        rresp_i = 2'b00; rlast_i = 1'b0;
                        tick;
                        fdone = 1'b1;
                    end
                    if (v.flush_after == k && !flushed) begin
                        rvalid_i = 1'b0; flush_i = 1'b1;
                        tick;
                        flush_i = 1'b0; flushed = 1'b1;
                    end
                    rvalid_i = 1'b1; rid_i = 4'd0; rdata_i = v.dbase + 32'(k);
                    rresp_i  = (k == v.err_beat) ? 2'b10 : 2'b00;
                    rlast_i  = (j == b - 1);
                    if (flushed) chk({name, "_drain_rready"}, 32'(rready_o), 32'd1);
                    tick;
                    k++;
                end
                rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00;
                rem -= b;
            end
        end
        wait_idle(name);

        chk({name, "_n_ar"}, 32'(q_araddr.size()), 32'(v.exp_nar));
        for (int i = 0; i < q_araddr.size() && i < v.exp_nar; i++) begin
            chk({name, "_araddr"}, q_araddr[i], v.addr + 32'(64 * i));
            chk({name, "_arlen"}, 32'(q_arlen[i]),
                32'((i == v.exp_nar - 1) ? v.exp_arlen_last : v.exp_arlen0));
        end
        chk({name, "_n_words"}, 32'(q_data.size()), 32'(v.exp_words));
        for (int i = 0; i < q_data.size() && i < v.exp_words; i++)
            chk({name, "_rdata"}, q_data[i], v.dbase + 32'(i));
        chk({name, "_rerr"}, 32'(rerr_o), 32'(v.exp_rerr));
        chk({name, "_req_ready_cnt"}, 32'(n_rr), 32'(v.exp_rr));
        chk({name, "_req_ready_off_hs"}, 32'(n_rr_off), 32'(v.exp_rr_off));
        chk({name, "_ar_stall"}, 32'(n_stall), 32'(v.exp_stall));
        chk({name, "_ar_unstable"}, 32'(n_unstable), 32'd0);
        chk({name, "_rr_rdv_overlap"}, 32'(n_overlap), 32'd0);
        if (v.exp_span > 0)
            chk({name, "_span"}, 32'(last_cyc - first_cyc + 1), 32'(v.exp_span));
    endtask

    initial begin
        //         addr          len dly err foreign flush dbase        nar  arlen0 arlenL words rerr rr off stall span
        vecs[0] = '{32'h1C000020,  8, 0, -1, 1'b0, -1, 32'h000000A0, 1, 8'd7,  8'd7, 8,  1'b0, 1, 0, 0, 8};
        vecs[1] = '{32'h00001004,  1, 3, -1, 1'b0, -1, 32'h00000055, 1, 8'd0,  8'd0, 1,  1'b0, 1, 0, 3, 1};
        vecs[2] = '{32'h80000000, 40, 1, -1, 1'b0, -1, 32'h00000100, 3, 8'd15, 8'd7, 40, 1'b0, 1, 0, 3, 0};
        vecs[3] = '{32'h00002000,  0, 0, -1, 1'b0, -1, 32'h00000000, 0, 8'd0,  8'd0, 0,  1'b0, 1, 1, 0, 0};
        vecs[4] = '{32'h00003000,  8, 0, -1, 1'b0,  3, 32'h000000C0, 1, 8'd7,  8'd7, 3,  1'b0, 1, 0, 0, 3};
        vecs[5] = '{32'h00004000,  4, 0,  1, 1'b1, -1, 32'h000000E0, 1, 8'd3,  8'd3, 4,  1'b1, 1, 0, 0, 0};
        vecs[6] = '{32'h00005000,  4, 2, -1, 1'b0, -1, 32'h000000F0, 1, 8'd3,  8'd3, 4,  1'b0, 1, 0, 2, 4};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_arvalid", 32'(arvalid_o), 32'd0);
        chk("rst_rready", 32'(rready_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rdata_valid", 32'(rdata_valid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_rerr", 32'(rerr_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_araddr", araddr_o, 32'd0);
        chk("rst_arlen", 32'(arlen_o), 32'd0);
        chk("const_ar_attrs", {19'd0, arsize_o, arburst_o, arid_o}, {19'd0, 3'b010, 2'b01, 4'd0});
        tick;

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Flush while AR is stalled: address phase must complete, then beats are drained silently.
        clear_mon();
        req_valid_i = 1'b1; req_addr_i = 32'h00006000; req_len_i = 8'd4;
        tick;
        req_valid_i = 1'b0;
        tick;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("far_arvalid_held", 32'(arvalid_o), 32'd1);
        chk("far_araddr_held", araddr_o, 32'h00006000);
        tick;
        arready_i = 1'b1;
        tick;
        arready_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            rvalid_i = 1'b1; rid_i = 4'd0; rdata_i = 32'h0000_0300 + 32'(j);
            rlast_i = (j == 3);
            chk("far_drain_rready", 32'(rready_o), 32'd1);
            tick;
        end
        rvalid_i = 1'b0; rlast_i = 1'b0;
        wait_idle("far");
        chk("far_n_ar", 32'(q_araddr.size()), 32'd1);
        chk("far_req_ready_cnt", 32'(n_rr), 32'd0);
        chk("far_n_words", 32'(q_data.size()), 32'd0);

        // Synchronous reset in the middle of a burst clears everything at once.
        clear_mon();
        req_valid_i = 1'b1; req_addr_i = 32'h00007000; req_len_i = 8'd8;
        tick;
        req_valid_i = 1'b0; arready_i = 1'b1;
        tick;
        arready_i = 1'b0;
        for (int j = 0; j < 2; j++) begin
            rvalid_i = 1'b1; rid_i = 4'd0; rdata_i = 32'h0000_0400 + 32'(j);
            rresp_i = 2'b11; rlast_i = 1'b0;
            tick;
        end
        rvalid_i = 1'b0; rresp_i = 2'b00;
        chk("mrst_busy_before", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        tick;
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_rready", 32'(rready_o), 32'd0);
        chk("mrst_arvalid", 32'(arvalid_o), 32'd0);
        chk("mrst_rdata_valid", 32'(rdata_valid_o), 32'd0);
        chk("mrst_rdata", rdata_o, 32'd0);
        chk("mrst_rerr", 32'(rerr_o), 32'd0);
        rst_n = 1'b1;
        tick;

        run_vec(vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
Responder for the instruction-cache refill/uncached-fetch request interface (addr_valid/addr/data_len/resp_ready/data_valid/data). It captures one word-granular read request, converts it into one or more AXI INCR read bursts of at most MAX_BURST beats, and streams the returned 32-bit words back in order. It sits between the icache and the AXI read channels (AR/R) of the memory interconnect.

Parameters:
AXI_ID, 4'd0, constant ARID driven on every burst; R beats with other RID are ignored
MAX_BURST, 16, maximum beats per AXI burst (power of 2, 1..16)
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush_i  in  1  abort current request (pipeline flush)
req_valid_i  in  1  request strobe from icache; may be a one-cycle pulse
req_addr_i  in  32  start byte address, word aligned
req_len_i  in  8  number of 32-bit words requested (0..255)
req_ready_o  out  1  one-cycle pulse: request accepted, data follows
rdata_valid_o  out  1  one returned word valid this cycle (no backpressure)
rdata_o  out  32  returned word
rerr_o  out  1  sticky per request: some beat had RRESP != OKAY
busy_o  out  1  bridge not in IDLE
arvalid_o  out  1  AXI AR valid
arready_i  in  1  AXI AR ready
araddr_o  out  32  burst start address
arlen_o  out  8  beats-1
arsize_o  out  3  constant 3'b010
arburst_o  out  2  constant 2'b01 (INCR)
arid_o  out  4  AXI_ID
rvalid_i  in  1  AXI R valid
rready_o  out  1  AXI R ready
rdata_i  in  32  AXI R data
rresp_i  in  2  AXI R response
rlast_i  in  1  AXI R last
rid_i  in  4  AXI R id

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk. Outputs after reset: arvalid_o=0, rready_o=0, req_ready_o=0, rdata_valid_o=0, rdata_o=0, rerr_o=0, busy_o=0, araddr_o=0, arlen_o=0; state IDLE; all counters 0.
- States: IDLE, AR, R, DRAIN.
- IDLE: on req_valid_i (with flush_i=0) latch addr, rem=req_len_i, clear rerr_o, first_q=1. If req_len_i==0: pulse req_ready_o next cycle, stay IDLE, no AXI traffic. Else -> AR. req_valid_i outside IDLE ignored.
- AR: arvalid_o=1, araddr_o=cur_addr, arlen_o=min(rem,MAX_BURST)-1, held stable until arready_i. On handshake: beats=min(rem,MAX_BURST); if first_q pulse req_ready_o that same cycle and clear first_q; -> R. Later bursts do not pulse req_ready_o.
- R: rready_o=1. Per beat with rvalid_i & rid_i==AXI_ID: rdata_valid_o=1, rdata_o=rdata_i registered (1-cycle latency R beat -> rdata_valid_o); rem-=1; cur_addr+=4; rerr_o|=(rresp_i!=0). On rlast_i (or beat counter reaching beats): rem==0 -> IDLE, else -> AR. rlast_i arriving early/late vs counter: counter is authoritative for rem, rlast_i ends the burst.
- rdata_valid_o never asserts in the same cycle as req_ready_o (R beat at earliest the cycle after AR handshake, plus register stage).
- Exactly one AXI burst outstanding at any time; no 4 KB boundary splitting beyond MAX_BURST (icache requests are block-aligned).
- flush_i: in IDLE, drop any same-cycle request. In AR before handshake: deassert arvalid_o only after handshake (AXI rule) -> if arvalid_o already high, complete AR then go DRAIN; if in AR with arvalid_o not yet driven, -> IDLE. In R: -> DRAIN. DRAIN: rready_o=1, rdata_valid_o forced 0, consume beats until rlast_i, then IDLE; remaining bursts not issued; req_ready_o suppressed during DRAIN.
- busy_o=1 in AR, R, DRAIN.
- Reset mid-burst: all state cleared immediately; interconnect is reset in the same domain.

Test Plan:
- Miss refill: req addr 0x1C000020 len 8, arready immediate, R beats 0xA0..0xA7 back-to-back -> one AR araddr=0x1C000020 arlen=7; req_ready_o one pulse; rdata_o 0xA0..0xA7 in order on 8 consecutive cycles; busy_o=0 after rlast.
- Uncached 1 word: addr 0x00001004 len 1, arready delayed 3 cycles -> arvalid held 3 cycles stable, arlen=0, single rdata_valid_o with data, req_ready_o only at handshake.
- Split: len 40, MAX_BURST 16 -> three ARs arlen=15,15,7 addrs base, base+0x40, base+0x80; 40 data words; single req_ready_o pulse.
- len 0 -> req_ready_o pulse, no arvalid_o, no data.
- Flush in R after 3 of 8 beats -> rdata_valid_o stays 0 for remaining 5 beats, rready_o=1 until rlast, then IDLE; new request then accepted normally.
- RRESP=SLVERR on beat 2 of 4, plus foreign RID beat -> rerr_o=1 until next request; foreign beat not forwarded, 4 words delivered.
